booth4_seq_mult_ctrl: RTL and testbench
=======================================

Name: booth4_seq_mult_ctrl

Overview:
Iterative radix-4 Booth multiplier controller for signed 16x16 products. It sequences one shared partial-product generator and one 32-bit accumulator over DATA_W/2 iterations. Negative partial products are formed by two's-complement inversion (~x+1), the same operation as the team's negation converter. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side, as the area-optimised alternative to the combinational Booth4/Wallace array.

Parameters:
DATA_W, 16, operand width; must be even; ITER = DATA_W/2 Booth iterations
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > ITER

Ports:
sys_clk  input  1  clock, all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a_i  input  DATA_W  multiplicand, signed two's complement
b_i  input  DATA_W  multiplier, signed two's complement
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product_o  output  2*DATA_W  signed product
busy_o  output  1  high in RUN or DONE

Behaviour:
- Reset: sys_rst_n low at a rising edge puts the state in IDLE. Reset values:
  - out_valid=0, product_o=0, busy_o=0
  - accumulator, counter, operand registers = 0
  - in_ready=1 once out of reset (in_ready = state==IDLE)
- Reset dominates at any point, including mid-RUN and in DONE with out_valid high. The product is discarded and out_valid drops the next cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A=a_i sign-extended to 2*DATA_W, and Q={b_i,1'b0} (DATA_W+1 bits).
  - Clear the accumulator and counter, then go to RUN.
- RUN:
  - in_ready=0, busy_o=1.
  - Each cycle decode Q[2:0]: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Negation is ~x+1 at 2*DATA_W bits.
  - acc <= acc + PP; A <= A<<2 (modulo 2*DATA_W); Q <= Q>>>2 (arithmetic shift); cnt <= cnt+1.
  - When cnt==ITER-1, perform the last accumulate and go to DONE.
- DONE:
  - out_valid=1 and product_o=acc, both held stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid deasserts the next cycle.
  - in_ready stays 0 in DONE; no accept overlaps the output handshake.
- Latency: operands accepted at edge T; out_valid high from edge T+ITER (T+8 at default).
- Minimum initiation interval: ITER+2 cycles (10 at default) with out_ready tied high.
- Arithmetic is exact two's complement over 2*DATA_W bits; overflow wraps modulo 2^(2*DATA_W). Wrap never occurs for valid signed inputs, including the -32768*-32768 corner.
- in_valid outside IDLE is ignored. a_i and b_i are sampled only at the accept edge.
- product_o holds its last value in IDLE and RUN. Only the DONE-entry edge updates it.

Optional Feature:
- Macro: BOOTH4_ZERO_SKIP_EN.
- Defined:
  - If a_i==0 or b_i==0 at accept, go IDLE -> DONE directly with acc=0.
  - out_valid is high at edge T+1.
  - The RUN state and counter are bypassed for that transaction.
- Undefined: every transaction takes the full ITER-cycle RUN path, with no operand-dependent latency.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid at T+8, product_o=32'h0000_000F; in_ready high again at T+10.
- a=-32768, b=-32768 -> 32'h4000_0000; a=-1, b=1 -> 32'hFFFF_FFFF; a=32767, b=-32768 -> 32'hC000_8000.
- Backpressure: a=-7, b=9, out_ready held 0 for 5 cycles after out_valid:
  - product_o stays 32'hFFFF_FFC1 and out_valid stays high throughout;
  - in_valid asserted during DONE is not accepted (in_ready=0).
- Reset mid-RUN: assert sys_rst_n=0 at cycle T+4:
  - next cycle state IDLE, out_valid=0, product_o=0, in_ready=1;
  - a new a=2, b=2 then yields 32'h0000_0004 at T'+8.
- Zero operand: a=0, b=1234:
  - with BOOTH4_ZERO_SKIP_EN, product_o=0 at T+1;
  - without it, product_o=0 at T+8.
- 1000 random signed pairs, with random in_valid/out_ready toggling -> every product_o equals $signed(a)*$signed(b). No transaction is dropped or duplicated.

Source files
------------

// File: rtl/booth4_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// booth4_seq_mult_ctrl
//   Iterative radix-4 Booth multiplier for signed DATA_W x DATA_W operands.
//   One partial-product generator and one 2*DATA_W accumulator are reused
//   over ITER = DATA_W/2 cycles. Valid/ready handshakes on both sides.
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (state IDLE)
//   a_i        in   multiplicand, signed [DATA_W-1:0]
//   b_i        in   multiplier, signed [DATA_W-1:0]
//   out_valid  out  product valid (state DONE)
//   out_ready  in   consumer accepts product
//   product_o  out  signed product [2*DATA_W-1:0]
//   busy_o     out  high in RUN or DONE
//
// Optional build macro
//   BOOTH4_ZERO_SKIP_EN : a zero operand at accept goes straight to DONE
//                         with a zero product, bypassing RUN.
// ---------------------------------------------------------------------------
module booth4_seq_mult_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   product_o,
  output logic                  busy_o
);

  localparam int PW   = 2 * DATA_W;
  localparam int ITER = DATA_W / 2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [PW-1:0]     r_a;      // multiplicand, pre-shifted by 2 per iteration
  logic [DATA_W:0]   r_q;      // {multiplier, 0}, arithmetic-shifted by 2
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_prod;

  logic [PW-1:0]     w_a2;
  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_sum;

  // Booth radix-4 recoding of the current 3-bit window
  always_comb begin
    w_a2 = r_a << 1;
    w_pp = '0;
    case (r_q[2:0])
      3'b001, 3'b010: w_pp = r_a;
      3'b011:         w_pp = w_a2;
      3'b100:         w_pp = ~w_a2 + PW'(1);
      3'b101, 3'b110: w_pp = ~r_a + PW'(1);
      default:        w_pp = '0;
    endcase
  end

  assign w_sum = r_acc + w_pp;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= {{DATA_W{a_i[DATA_W-1]}}, a_i};
            r_q   <= {b_i, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
`ifdef BOOTH4_ZERO_SKIP_EN
            if (a_i == '0 || b_i == '0) begin
              r_prod  <= '0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
`else
            r_state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          r_acc <= w_sum;
          r_a   <= r_a << 2;
          r_q   <= {{2{r_q[DATA_W]}}, r_q[DATA_W:2]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            // product register only changes on DONE entry
            r_prod  <= w_sum;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy_o    = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign product_o = r_prod;

endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
module tb_booth4_seq_mult_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product_o;
  logic        busy_o;

  int n_err = 0;
  int n_chk = 0;

  booth4_seq_mult_ctrl #(.DATA_W(16), .CNT_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product_o (product_o),
    .busy_o    (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // drive one operand pair for a single accept edge
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    tick();
    in_valid = 1'b0;
  endtask

  // cycles after the accept edge until out_valid is seen (bounded)
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  function automatic int ref_mul(input logic signed [15:0] a, input logic signed [15:0] b);
    return int'(a) * int'(b);
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    case ($urandom_range(7, 0))
      0: begin
        case ($urandom_range(4, 0))
          0: v = 16'h8000;
          1: v = 16'h7FFF;
          2: v = 16'hFFFF;
          3: v = 16'h0001;
          default: v = 16'h0000;
        endcase
      end
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  int lat;
  int zlat;
  logic signed [15:0] ra, rb;
  logic [31:0] q[$];
  int sent, got, cyc;
  logic acc_now, dlv_now;

  initial begin
`ifdef BOOTH4_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = 8;
`endif
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i = '0;
    b_i = '0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product",   product_o,      32'd0);
    chk("rst_busy",      32'(busy_o),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    sys_rst_n = 1'b1;
    tick();

    // 3*5: latency 8, ready again after the output handshake
    send(16'd3, 16'd5);
    chk("run_busy",     32'(busy_o),   32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    wait_out(lat);
    chk("lat_3x5",  32'(lat), 32'd8);
    chk("prod_3x5", product_o, 32'h0000_000F);
    tick();
    chk("ii_out_valid", 32'(out_valid), 32'd0);
    chk("ii_in_ready",  32'(in_ready),  32'd1);

    send(16'h8000, 16'h8000);
    wait_out(lat);
    chk("lat_min_min",  32'(lat), 32'd8);
    chk("prod_min_min", product_o, 32'h4000_0000);
    tick();

    send(16'hFFFF, 16'h0001);
    wait_out(lat);
    chk("prod_m1_1", product_o, 32'hFFFF_FFFF);
    tick();

    send(16'h7FFF, 16'h8000);
    wait_out(lat);
    chk("prod_max_min", product_o, 32'hC000_8000);
    tick();

    // backpressure in DONE, with in_valid offered and refused
    out_ready = 1'b0;
    send(16'hFFF9, 16'd9);
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd8);
    in_valid = 1'b1;
    a_i = 16'd11;
    b_i = 16'd13;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_product",   product_o,      32'hFFFF_FFC1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_hold_end", product_o, 32'hFFFF_FFC1);
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_not_accepted",  32'(busy_o),    32'd0);

    // reset in the middle of RUN
    send(16'd100, 16'd200);
    repeat (3) tick();
    sys_rst_n = 1'b0;
    tick();
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_product",   product_o,      32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    chk("mrst_busy",      32'(busy_o),    32'd0);
    sys_rst_n = 1'b1;
    tick();
    send(16'd2, 16'd2);
    wait_out(lat);
    chk("mrst_lat",  32'(lat), 32'd8);
    chk("mrst_prod", product_o, 32'h0000_0004);
    tick();

    // zero multiplicand; latency depends on the build option
    send(16'd5, 16'd7);
    wait_out(lat);
    chk("pre_zero_prod", product_o, 32'd35);
    tick();
    send(16'd0, 16'd1234);
    wait_out(lat);
    chk("zero_lat",  32'(lat), 32'(zlat));
    chk("zero_prod", product_o, 32'd0);
    tick();

    // random traffic against a queue-based reference
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 1000 || q.size() > 0) && cyc < 40000) begin
      in_valid  = (sent < 1000) && ($urandom_range(1, 0) == 1);
      ra = rnd16();
      rb = rnd16();
      a_i = ra;
      b_i = rb;
      out_ready = ($urandom_range(9, 0) < 7);
      acc_now = in_valid && in_ready;
      dlv_now = out_valid && out_ready;
      if (dlv_now) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          chk("rnd_prod", product_o, q.pop_front());
          got++;
        end
      end
      tick();
      cyc++;
      if (acc_now) begin
        q.push_back(ref_mul(ra, rb));
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("rnd_sent",  32'(sent), 32'd1000);
    chk("rnd_got",   32'(got),  32'd1000);
    chk("rnd_queue", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
